// File: rtl/ocl_axil_master.sv
// AXI4-Lite initiator: one register read or write command in flight, with a
// response timeout and a drain of any late response before the next command is taken.
module ocl_axil_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                m_awvalid,
    output logic [ADDR_W-1:0]   m_awaddr,
    input  logic                m_awready,
    output logic                m_wvalid,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_wready,
    input  logic                m_bvalid,
    input  logic [1:0]          m_bresp,
    output logic                m_bready,
    output logic                m_arvalid,
    output logic [ADDR_W-1:0]   m_araddr,
    input  logic                m_arready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    output logic                m_rready,
    output logic                busy
);
    // IDLE: wait cmd | WR_REQ: AW/W pending | WR_RESP: wait B | RD_REQ: AR pending | RD_RESP: wait R | RSP: hold response
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    localparam int               CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                stale_b_q, stale_b_d, stale_r_q, stale_r_d;
    logic                expired;
    logic                cmd_ready_d, rsp_valid_d, rsp_timeout_d, busy_d;
    logic [DATA_W-1:0]   rsp_rdata_d, wdata_d;
    logic [1:0]          rsp_resp_d;
    logic                awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
    logic [ADDR_W-1:0]   awaddr_d, araddr_d;
    logic [DATA_W/8-1:0] wstrb_d;

    assign expired = TMO_EN && (cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stale_b_d     = stale_b_q;
        stale_r_d     = stale_r_q;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        awvalid_d     = m_awvalid;
        wvalid_d      = m_wvalid;
        arvalid_d     = m_arvalid;
        awaddr_d      = m_awaddr;
        araddr_d      = m_araddr;
        wdata_d       = m_wdata;
        wstrb_d       = m_wstrb;

        // A late response from a timed-out transaction is swallowed here.
        if (stale_b_q && m_bvalid && m_bready) stale_b_d = 1'b0;
        if (stale_r_q && m_rvalid && m_rready) stale_r_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (m_awvalid && m_awready) awvalid_d = 1'b0;
                if (m_wvalid && m_wready)   wvalid_d  = 1'b0;
                if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                    cnt_d   = CNT_LOAD;
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_bvalid && m_bready) begin
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = m_bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (expired) begin
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = 2'b10;
                    rsp_timeout_d = 1'b1;
                    stale_b_d     = 1'b1;
                    state_d       = RSP;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_REQ: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    cnt_d     = CNT_LOAD;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_rvalid && m_rready) begin
                    rsp_rdata_d   = m_rdata;
                    rsp_resp_d    = m_rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = RSP;
                end else if (expired) begin
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = 2'b10;
                    rsp_timeout_d = 1'b1;
                    stale_r_d     = 1'b1;
                    state_d       = RSP;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RSP: begin
                if (rsp_valid && rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rsp_valid_d = (state_d == RSP);
        bready_d    = (state_d == WR_RESP) || stale_b_d;
        rready_d    = (state_d == RD_RESP) || stale_r_d;
        cmd_ready_d = (state_d == IDLE) && !stale_b_d && !stale_r_d;
        busy_d      = !cmd_ready_d;
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stale_b_q   <= 1'b0;
            stale_r_q   <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b00;
            rsp_timeout <= 1'b0;
            m_awvalid   <= 1'b0;
            m_awaddr    <= '0;
            m_wvalid    <= 1'b0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            m_bready    <= 1'b0;
            m_arvalid   <= 1'b0;
            m_araddr    <= '0;
            m_rready    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stale_b_q   <= stale_b_d;
            stale_r_q   <= stale_r_d;
            cmd_ready   <= cmd_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_resp    <= rsp_resp_d;
            rsp_timeout <= rsp_timeout_d;
            m_awvalid   <= awvalid_d;
            m_awaddr    <= awaddr_d;
            m_wvalid    <= wvalid_d;
            m_wdata     <= wdata_d;
            m_wstrb     <= wstrb_d;
            m_bready    <= bready_d;
            m_arvalid   <= arvalid_d;
            m_araddr    <= araddr_d;
            m_rready    <= rready_d;
            busy        <= busy_d;
        end
    end
endmodule

// File: tb/tb_ocl_axil_master.sv
// Bench for ocl_axil_master: reactive AXI4-Lite responder, transaction-level
// expectation queue checked every cycle, plus directed literal checks.
module tb_ocl_axil_master;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, busy;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    ocl_axil_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Responder behaviour for the next transaction
    int          cfg_aw_wait, cfg_w_wait, cfg_ar_wait, cfg_b_wait, cfg_r_wait;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    bit          cfg_no_resp;

    typedef struct {
        logic        write;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  wstrb;
        logic [1:0]  resp;
        logic        tmo;
        int          acc, aw_end, w_end, ar_end, rsp_cyc;
    } exp_t;

    exp_t q[$];
    int   n_aw, n_w, n_b, n_ar, n_r, n_wr, n_rd, n_rsp;
    bit   acc_evt;
    int   acc_cyc;
    bit   en;

    // Handshake monitor and transaction-level model
    always @(posedge clk) begin : model
        exp_t e;
        int   ent;
        bit   ok;
        if (!rst_n) begin
            q.delete();
            n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
            n_wr = 0; n_rd = 0; n_rsp = 0;
            en = 1'b0;
        end else begin
            en = 1'b1;
            if (m_awvalid && m_awready) n_aw++;
            if (m_wvalid && m_wready)   n_w++;
            if (m_bvalid && m_bready)   n_b++;
            if (m_arvalid && m_arready) n_ar++;
            if (m_rvalid && m_rready)   n_r++;
            if (rsp_valid && rsp_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                n_rsp++;
            end
            if (cmd_valid && cmd_ready) begin
                e.write = cmd_write;
                e.addr  = cmd_addr;
                e.wdata = cmd_wdata;
                e.wstrb = cmd_wstrb;
                e.acc   = cyc;
                if (cmd_write) begin
                    e.aw_end = cyc + 1 + cfg_aw_wait;
                    e.w_end  = cyc + 1 + cfg_w_wait;
                    e.ar_end = cyc;
                    ent      = imax(e.aw_end, e.w_end) + 1;
                    ok       = !cfg_no_resp && (cfg_b_wait <= T);
                    e.rsp_cyc = ent + (ok ? cfg_b_wait : T) + 1;
                    e.resp   = ok ? cfg_bresp : 2'b10;
                    e.rdata  = 32'h0;
                    n_wr++;
                end else begin
                    e.aw_end = cyc;
                    e.w_end  = cyc;
                    e.ar_end = cyc + 1 + cfg_ar_wait;
                    ent      = e.ar_end + 1;
                    ok       = !cfg_no_resp && (cfg_r_wait <= T);
                    e.rsp_cyc = ent + (ok ? cfg_r_wait : T) + 1;
                    e.resp   = ok ? cfg_rresp : 2'b10;
                    e.rdata  = ok ? cfg_rdata : 32'h0;
                    n_rd++;
                end
                e.tmo   = !ok;
                q.push_back(e);
                acc_evt = 1'b1;
                acc_cyc = cyc;
            end
        end
        cyc++;
    end

    // Reactive responder, driven away from the active edge
    int aw_age, w_age, ar_age, b_age, r_age;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
            m_bvalid = 1'b0; m_rvalid = 1'b0;
            aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        end else begin
            if (m_awvalid) begin m_awready = (aw_age == cfg_aw_wait); aw_age++; end
            else begin m_awready = 1'b0; aw_age = 0; end
            if (m_wvalid) begin m_wready = (w_age == cfg_w_wait); w_age++; end
            else begin m_wready = 1'b0; w_age = 0; end
            if (m_arvalid) begin m_arready = (ar_age == cfg_ar_wait); ar_age++; end
            else begin m_arready = 1'b0; ar_age = 0; end
            if ((imin(n_aw, n_w) > n_b) && m_bready && !cfg_no_resp) begin
                m_bvalid = (b_age >= cfg_b_wait); b_age++;
            end else begin
                m_bvalid = 1'b0; b_age = 0;
            end
            if ((n_ar > n_r) && m_rready && !cfg_no_resp) begin
                m_rvalid = (r_age >= cfg_r_wait); r_age++;
            end else begin
                m_rvalid = 1'b0; r_age = 0;
            end
        end
        m_bresp = m_bvalid ? cfg_bresp : 2'b00;
        m_rresp = m_rvalid ? cfg_rresp : 2'b00;
        m_rdata = m_rvalid ? cfg_rdata : 32'h0;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin : compare
        exp_t h;
        bit   has, ev, er;
        if (en && rst_n) begin
            has = (q.size() > 0);
            if (has) h = q[0];
            ev = has && (cyc >= h.rsp_cyc);
            chk1("rsp_valid", rsp_valid, ev);
            if (ev && rsp_valid) begin
                chk32("rsp_rdata", rsp_rdata, h.rdata);
                chk32("rsp_resp", 32'(rsp_resp), 32'(h.resp));
                chk1("rsp_timeout", rsp_timeout, h.tmo);
            end
            er = !has && (n_b == n_wr) && (n_r == n_rd);
            chk1("cmd_ready", cmd_ready, er);
            chk1("busy", busy, !er);
            chk1("m_awvalid", m_awvalid, has && (cyc > h.acc) && (cyc <= h.aw_end));
            chk1("m_wvalid", m_wvalid, has && (cyc > h.acc) && (cyc <= h.w_end));
            chk1("m_arvalid", m_arvalid, has && (cyc > h.acc) && (cyc <= h.ar_end));
            if (has && m_awvalid) chk32("m_awaddr", m_awaddr, h.addr);
            if (has && m_wvalid) begin
                chk32("m_wdata", m_wdata, h.wdata);
                chk32("m_wstrb", 32'(m_wstrb), 32'(h.wstrb));
            end
            if (has && m_arvalid) chk32("m_araddr", m_araddr, h.addr);
        end
    end

    task automatic do_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int acc);
        acc_evt   = 1'b0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        cmd_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (acc_evt) break;
        end
        cmd_valid = 1'b0;
        chk1("cmd_accept", acc_evt, 1'b1);
        acc = acc_cyc;
    endtask

    task automatic wait_rsp();
        int n0 = n_rsp;
        for (int k = 0; k < 100 && n_rsp == n0; k++) @(negedge clk);
        chk1("rsp_handshake", n_rsp != n0, 1'b1);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 100 && !rsp_valid; k++) @(negedge clk);
        chk1("rsp_valid_seen", rsp_valid, 1'b1);
    endtask

    task automatic at_cyc(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic cfg_default();
        cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_b_wait = 0; cfg_r_wait = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0; cfg_no_resp = 1'b0;
    endtask

    function automatic logic any_out();
        return |{cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, m_awvalid, m_awaddr,
                 m_wvalid, m_wdata, m_wstrb, m_bready, m_arvalid, m_araddr, m_rready, busy};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a, a2, e, nb0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        cfg_default();
        repeat (3) @(negedge clk);
        chk1("reset_outputs_zero", any_out(), 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk1("cmd_ready_after_reset", cmd_ready, 1'b1);

        // Minimum-latency write
        do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, a);
        at_cyc(a + 1);
        chk1("wr_awvalid_c1", m_awvalid, 1'b1);
        chk1("wr_wvalid_c1", m_wvalid, 1'b1);
        at_cyc(a + 2);
        chk1("wr_bready_c2", m_bready, 1'b1);
        at_cyc(a + 3);
        chk1("wr_rsp_valid_c3", rsp_valid, 1'b1);
        chk32("wr_rsp_resp", 32'(rsp_resp), 32'h0);
        chk1("wr_rsp_timeout", rsp_timeout, 1'b0);
        wait_rsp();

        // Read with 5 AR wait cycles and 5 R wait cycles
        cfg_ar_wait = 5; cfg_r_wait = 5; cfg_rdata = 32'h12345678;
        do_cmd(1'b0, 32'h24, 32'h0, 4'h0, a);
        wait_valid();
        chk32("rd_rdata", rsp_rdata, 32'h12345678);
        chk32("rd_latency", 32'(cyc - a), 32'd13);
        wait_rsp();
        cfg_default();

        // W accepted three cycles ahead of AW
        cfg_aw_wait = 3;
        nb0 = n_b;
        do_cmd(1'b1, 32'h30, 32'hCAFEF00D, 4'h5, a);
        at_cyc(a + 2);
        chk1("wfirst_wvalid_dropped", m_wvalid, 1'b0);
        chk1("wfirst_awvalid_held", m_awvalid, 1'b1);
        at_cyc(a + 4);
        chk1("wfirst_awvalid_c4", m_awvalid, 1'b1);
        at_cyc(a + 5);
        chk1("wfirst_awvalid_c5", m_awvalid, 1'b0);
        wait_rsp();
        repeat (3) @(negedge clk);
        chk32("wfirst_one_b", 32'(n_b - nb0), 32'd1);
        cfg_default();

        // Read timeout, then late R drained
        cfg_no_resp = 1'b1;
        do_cmd(1'b0, 32'h40, 32'h0, 4'h0, a);
        e = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_rready) begin e = cyc; break; end
        end
        chk32("to_rd_resp_entry", 32'(e), 32'(a + 2));
        at_cyc(e + T);
        chk1("to_no_rsp_yet", rsp_valid, 1'b0);
        at_cyc(e + T + 1);
        chk1("to_rsp_valid", rsp_valid, 1'b1);
        chk32("to_rsp_resp", 32'(rsp_resp), 32'h2);
        chk1("to_rsp_timeout", rsp_timeout, 1'b1);
        chk32("to_rsp_rdata", rsp_rdata, 32'h0);
        wait_rsp();
        repeat (3) @(negedge clk);
        chk1("to_stale_cmd_ready", cmd_ready, 1'b0);
        chk1("to_stale_rready", m_rready, 1'b1);
        cfg_r_wait = 0; cfg_rdata = 32'hBAD0BAD0; cfg_no_resp = 1'b0;
        for (int k = 0; k < 10 && !cmd_ready; k++) @(negedge clk);
        chk1("to_cmd_ready_back", cmd_ready, 1'b1);
        chk1("to_late_r_taken", n_r == n_rd, 1'b1);
        cfg_default();

        // SLVERR on B
        cfg_bresp = 2'b10;
        do_cmd(1'b1, 32'h50, 32'h11223344, 4'h3, a);
        wait_valid();
        chk32("slverr_resp", 32'(rsp_resp), 32'h2);
        chk1("slverr_timeout", rsp_timeout, 1'b0);
        wait_rsp();
        cfg_default();

        // B exactly at expiry is normal; one cycle later is a timeout
        cfg_b_wait = T;
        do_cmd(1'b1, 32'h54, 32'h1, 4'h1, a);
        wait_valid();
        chk1("b_at_expiry_normal", rsp_timeout, 1'b0);
        chk32("b_at_expiry_lat", 32'(cyc - a), 32'(T + 3));
        wait_rsp();
        cfg_b_wait = T + 1;
        do_cmd(1'b1, 32'h58, 32'h2, 4'h2, a);
        wait_valid();
        chk1("b_after_expiry_tmo", rsp_timeout, 1'b1);
        wait_rsp();
        for (int k = 0; k < 10 && !cmd_ready; k++) @(negedge clk);
        chk1("b_after_expiry_drained", cmd_ready, 1'b1);
        cfg_default();

        // Response held while rsp_ready is low
        cfg_rresp = 2'b11; cfg_rdata = 32'hA5A55A5A;
        rsp_ready = 1'b0;
        do_cmd(1'b0, 32'h60, 32'h0, 4'h0, a);
        wait_valid();
        repeat (3) @(negedge clk);
        chk1("hold_rsp_valid", rsp_valid, 1'b1);
        chk32("hold_rsp_rdata", rsp_rdata, 32'hA5A55A5A);
        chk32("hold_rsp_resp", 32'(rsp_resp), 32'h3);
        rsp_ready = 1'b1;
        wait_rsp();
        cfg_default();

        // Back-to-back write then read
        cfg_rdata = 32'h0BADCAFE;
        do_cmd(1'b1, 32'h70, 32'h76543210, 4'hC, a);
        do_cmd(1'b0, 32'h74, 32'h0, 4'h0, a2);
        chk32("b2b_gap", 32'(a2 - a), 32'd4);
        wait_rsp();
        cfg_default();

        // Reset during WR_REQ
        cfg_aw_wait = 10; cfg_w_wait = 10;
        do_cmd(1'b1, 32'h80, 32'h55AA55AA, 4'hF, a);
        at_cyc(a + 2);
        chk1("rst_mid_awvalid", m_awvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk1("rst_mid_outputs_zero", any_out(), 1'b0);
        repeat (2) @(posedge clk);
        cfg_default();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk1("rst_mid_cmd_ready", cmd_ready, 1'b1);
        do_cmd(1'b1, 32'h84, 32'h13579BDF, 4'hF, a);
        wait_valid();
        chk32("rst_mid_next_resp", 32'(rsp_resp), 32'h0);
        chk32("rst_mid_next_lat", 32'(cyc - a), 32'd3);
        wait_rsp();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ocl_axil_master.md
# ocl_axil_master

Command-driven AXI4-Lite initiator on `clk_main_a0`. It turns single register read/write commands from an internal requester into AXI4-Lite transactions toward any AXI4-Lite responder, such as the OCL register slice or the `F1Shim` control port, and returns the response. It issues one transaction at a time and reports a response timeout. It is used for CL-side self-initialisation and for loopback testing of the OCL register path.

## Interface
- `ADDR_W`, default 32: AXI address width.
- `DATA_W`, default 32: AXI data width. Fixed at 32.
- `TIMEOUT_CYC`, default 4096: response-wait limit in cycles. 0 disables the timeout.

Ports:
- `clk_main_a0` in 1: clock.
- `rst_main_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in 32: write data.
- `cmd_wstrb` in 4: write strobes.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_rdata` out 32: read data. 0 for writes.
- `rsp_resp` out 2: BRESP or RRESP; 2'b10 on timeout.
- `rsp_timeout` out 1: the response came from a timeout.
- `m_awvalid` out 1, `m_awaddr` out ADDR_W, `m_awready` in 1.
- `m_wvalid` out 1, `m_wdata` out 32, `m_wstrb` out 4, `m_wready` in 1.
- `m_bvalid` in 1, `m_bresp` in 2, `m_bready` out 1.
- `m_arvalid` out 1, `m_araddr` out ADDR_W, `m_arready` in 1.
- `m_rvalid` in 1, `m_rdata` in 32, `m_rresp` in 2, `m_rready` out 1.
- `busy` out 1: high when state ≠ IDLE or `stale` is set.

## Operation
- FSM states:
  - IDLE
  - WR_REQ: AW and W pending.
  - WR_RESP
  - RD_REQ
  - RD_RESP
  - RSP
- IDLE:
  - `cmd_ready` = 1 iff `stale` = 0.
  - On accept, latch all command fields.
  - Go to WR_REQ with `m_awvalid` = `m_wvalid` = 1, or to RD_REQ with `m_arvalid` = 1.
- WR_REQ:
  - AW and W are independent. Each valid drops the cycle after its own handshake.
  - Go to WR_RESP when both have completed; simultaneous or either order is legal.
- WR_RESP:
  - `m_bready` = 1.
  - On `m_bvalid`, capture `m_bresp` and set `rsp_rdata` = 0. Go to RSP.
- RD_REQ: `m_arvalid` = 1 until `m_arready`, then go to RD_RESP.
- RD_RESP:
  - `m_rready` = 1.
  - On `m_rvalid`, capture `m_rdata` and `m_rresp`. Go to RSP.
- RSP: `rsp_valid` = 1 with held fields until `rsp_ready`, then go to IDLE.
- Valids are never withdrawn before their handshake (AXI rule). Address and data are stable while valid.
- Timeout counter:
  - Counts only in WR_RESP and RD_RESP. Clears on entry.
  - At `TIMEOUT_CYC` cycles without B/R, go to RSP with `rsp_resp` = 2'b10, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - Set `stale_b` or `stale_r` to match the waiting channel.
- Stale drain:
  - While `stale_b` or `stale_r` is set, `m_bready` or `m_rready` stays 1.
  - The late response is discarded and the flag clears on its handshake.
  - `cmd_ready` stays 0 until the flag clears. This prevents mismatched responses.
- A B or R arriving in the same cycle the counter expires counts as a normal response. No timeout.
- Reset mid-transaction returns to IDLE immediately and clears the stale flags. Outstanding AXI state in the responder is the system's responsibility, since the whole CL resets together.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Reset values are 0 for:
  - all valids and readies
  - `rsp_*`
  - `busy`
  - the address, data and strobe outputs
- Write, minimum latency:
  - cmd accept at cycle 0.
  - AW/W valid at cycle 1. If ready at cycle 1, `m_bready` = 1 at cycle 2.
  - B at cycle 2 gives `rsp_valid` at cycle 3.
- Read, minimum latency: accept at 0, AR at 1, R at 2, `rsp_valid` at 3.
- Back-to-back: with `rsp_ready` held 1, the next command is accepted in the cycle after the response handshake. Peak rate is one transaction per 4 cycles.
- Timeout fires exactly `TIMEOUT_CYC` cycles after entering WR_RESP or RD_RESP: `rsp_valid` rises in the following cycle.

## Test plan
- Write `0x10` / `0xDEADBEEF` / strb `0xF`, responder always ready and B OKAY at first opportunity:
  - AW/W valid at cycle 1.
  - `rsp_valid` at cycle 3 with `rsp_resp` = 0, `rsp_timeout` = 0.
- Read `0x24`, responder returns `0x12345678` with RRESP 2'b00 after 5 wait cycles:
  - `rsp_rdata` = `0x12345678`.
  - `m_arvalid` held stable throughout the wait.
- Write with `m_wready` asserted 3 cycles before `m_awready`:
  - `m_wvalid` drops the cycle after the W handshake.
  - `m_awvalid` stays high until the AW handshake; exactly one B is consumed.
- `TIMEOUT_CYC` = 16, read with R never returned:
  - `rsp_resp` = 2'b10 and `rsp_timeout` = 1 exactly 17 cycles after RD_RESP entry.
  - `cmd_ready` = 0 until a late R is injected, which is discarded; then `cmd_ready` returns to 1.
- SLVERR propagation: B with 2'b10 gives `rsp_resp` = 2'b10 with `rsp_timeout` = 0.
- Assert `rst_main_n` low while in WR_REQ with `m_awvalid` = 1:
  - All outputs are 0 asynchronously.
  - After release, `cmd_ready` = 1 in the first cycle and the next command completes normally.
